// File: rtl/rvsteel_spi_pkg.sv
// Shared types and constants for the rvsteel SPI target.
package rvsteel_spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // SPI mode number is {cpol, cpha}.
    typedef enum logic [1:0] {
        MODE0 = 2'd0,
        MODE1 = 2'd1,
        MODE2 = 2'd2,
        MODE3 = 2'd3
    } spi_mode_t;

    localparam logic [7:0] DEFAULT_IDLE_FILL = 8'h00;

endpackage

// File: rtl/rvsteel_sync.sv
// Multi-flop synchronizer for one asynchronous input, with a selectable reset level.
module rvsteel_sync #(
    parameter int   STAGES      = 2,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) chain <= {STAGES{RESET_VALUE}};
        else       chain <= {chain[STAGES-2:0], din};
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/rvsteel_spi_target.sv
// SPI target: oversampled sclk/pico/cs, one-byte transmit buffer, strobed receive byte.
module rvsteel_spi_target
    import rvsteel_spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_FILL   = DEFAULT_IDLE_FILL
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cpol,
    input  logic       cpha,
    input  logic       sclk,
    input  logic       pico,
    input  logic       cs,
    output logic       poci,
    output logic       poci_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_write,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       underrun
);

    logic sclk_s, pico_s, cs_s;

    rvsteel_sync #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_sclk (
        .clock(clock), .reset(reset), .din(sclk), .dout(sclk_s)
    );
    rvsteel_sync #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_pico (
        .clock(clock), .reset(reset), .din(pico), .dout(pico_s)
    );
    rvsteel_sync #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_cs (
        .clock(clock), .reset(reset), .din(cs), .dout(cs_s)
    );

    // A registered copy of each synchronized pin feeds the edge compare, so a pin
    // change is seen SYNC_STAGES+1 cycles later; pico is delayed identically to sclk.
    logic sclk_d, sclk_q, pico_d, cs_d, cs_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_d <= 1'b0;
            sclk_q <= 1'b0;
            pico_d <= 1'b0;
            cs_d   <= 1'b1;
            cs_q   <= 1'b1;
        end else begin
            sclk_d <= sclk_s;
            sclk_q <= sclk_d;
            pico_d <= pico_s;
            cs_d   <= cs_s;
            cs_q   <= cs_d;
        end
    end

    state_t    state, state_next;
    spi_mode_t mode_q;

    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic lead_edge, trail_edge, edge_ok, sample_edge, shift_edge;

    assign sclk_rise = sclk_d & ~sclk_q;
    assign sclk_fall = ~sclk_d & sclk_q;
    assign cs_fall   = ~cs_d & cs_q;
    assign cs_rise   = cs_d & ~cs_q;

    // Leading edge leaves the idle (cpol) level.
    assign lead_edge   = mode_q[1] ? sclk_fall : sclk_rise;
    assign trail_edge  = mode_q[1] ? sclk_rise : sclk_fall;
    assign edge_ok     = (state == ACTIVE) && !cs_rise;
    assign sample_edge = edge_ok && (mode_q[0] ? trail_edge : lead_edge);
    assign shift_edge  = edge_ok && (mode_q[0] ? lead_edge : trail_edge);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        poci_oe    = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) state_next = ACTIVE;
            end
            ACTIVE: begin
                busy    = 1'b1;
                poci_oe = 1'b1;
                if (cs_rise) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    logic [2:0] bit_cnt;
    logic       byte_pending;
    logic [6:0] rx_shift;
    logic [7:0] tx_shift;
    logic [7:0] tx_buf;
    logic [7:0] next_byte;
    logic       start_at_cs, start_at_shift, byte_start;

    assign start_at_cs    = (state == IDLE) && cs_fall;
    assign start_at_shift = shift_edge && byte_pending;
    assign byte_start     = start_at_cs || start_at_shift;
    assign next_byte      = tx_ready ? IDLE_FILL : tx_buf;

    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q       <= MODE0;
            bit_cnt      <= 3'd0;
            byte_pending <= 1'b0;
            rx_shift     <= 7'd0;
            tx_shift     <= 8'd0;
            tx_buf       <= 8'd0;
            tx_ready     <= 1'b1;
            poci         <= 1'b0;
            rx_data      <= 8'd0;
            rx_valid     <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            underrun <= 1'b0;

            if (start_at_cs) begin
                mode_q       <= spi_mode_t'({cpol, cpha});
                bit_cnt      <= 3'd0;
                byte_pending <= 1'b0;
                // With cpha=1 bit 7 waits for the first shift edge.
                if (cpha) begin
                    tx_shift <= next_byte;
                    poci     <= 1'b0;
                end else begin
                    tx_shift <= {next_byte[6:0], 1'b0};
                    poci     <= next_byte[7];
                end
            end else if ((state == ACTIVE) && cs_rise) begin
                poci         <= 1'b0;
                byte_pending <= 1'b0;
            end else begin
                if (shift_edge) begin
                    if (byte_pending) begin
                        byte_pending <= 1'b0;
                        tx_shift     <= {next_byte[6:0], 1'b0};
                        poci         <= next_byte[7];
                    end else begin
                        tx_shift <= {tx_shift[6:0], 1'b0};
                        poci     <= tx_shift[7];
                    end
                end
                if (sample_edge) begin
                    rx_shift <= {rx_shift[5:0], pico_d};
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_data      <= {rx_shift, pico_d};
                        rx_valid     <= 1'b1;
                        byte_pending <= 1'b1;
                    end
                end
            end

            if (byte_start) begin
                if (tx_ready) underrun <= 1'b1;
                else          tx_ready <= 1'b1;
            end
            // A write racing an empty-buffer byte start lands for the following byte.
            if (tx_write && tx_ready) begin
                tx_buf   <= tx_data;
                tx_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rvsteel_spi_target.sv
// Directed bench for rvsteel_spi_target: a behavioural SPI controller plus hand-computed expectations.
module tb_rvsteel_spi_target;

    localparam int HALF = 8;

    logic       clock = 1'b0;
    logic       reset, cpol, cpha, sclk, pico, cs, tx_write;
    logic       poci, poci_oe, tx_ready, rx_valid, busy, underrun;
    logic [7:0] tx_data, rx_data;

    int total = 0;
    int bad = 0;
    int rx_count = 0;
    int ur_count = 0;
    int rx_base, ur_base;
    logic [7:0] miso, miso2;

    always #5 clock = ~clock;

    rvsteel_spi_target dut (
        .clock(clock), .reset(reset), .cpol(cpol), .cpha(cpha),
        .sclk(sclk), .pico(pico), .cs(cs),
        .poci(poci), .poci_oe(poci_oe),
        .tx_data(tx_data), .tx_write(tx_write), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .underrun(underrun)
    );

    always @(negedge clock) begin
        if (rx_valid) rx_count++;
        if (underrun) ur_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic write_tx(input logic [7:0] d);
        tx_data  = d;
        tx_write = 1'b1;
        @(negedge clock);
        tx_write = 1'b0;
    endtask

    // Controller side: drives pico on shift edges, samples poci on sample edges, MSB first.
    task automatic spi_xfer(input logic [1:0] mode, input logic [7:0] mosi, input int nbits,
                            output logic [7:0] rd);
        logic cp, ch;
        cp = mode[1];
        ch = mode[0];
        rd = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!ch) pico = mosi[i];
            wait_cycles(HALF);
            sclk = ~cp;
            if (ch) pico = mosi[i];
            else    rd = {rd[6:0], poci};
            wait_cycles(HALF);
            sclk = cp;
            if (ch) rd = {rd[6:0], poci};
        end
    endtask

    task automatic cs_low;
        cs = 1'b0;
        wait_cycles(HALF);
    endtask

    task automatic cs_high;
        wait_cycles(HALF);
        cs = 1'b1;
        wait_cycles(HALF);
    endtask

    initial begin
        reset = 1'b1; cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; pico = 1'b0;
        cs = 1'b1; tx_write = 1'b0; tx_data = 8'h00;
        wait_cycles(4);
        reset = 1'b0;
        wait_cycles(2);
        check("reset poci", poci, 0);
        check("reset poci_oe", poci_oe, 0);
        check("reset tx_ready", tx_ready, 1);
        check("reset rx_data", rx_data, 8'h00);
        check("reset rx_valid", rx_valid, 0);
        check("reset busy", busy, 0);
        check("reset underrun", underrun, 0);

        // Mode 0, buffered A5, controller sends 3C.
        write_tx(8'hA5);
        check("m0 tx_ready after write", tx_ready, 0);
        rx_base = rx_count; ur_base = ur_count;
        cs_low();
        check("m0 tx_ready at byte start", tx_ready, 1);
        check("m0 busy", busy, 1);
        check("m0 poci_oe", poci_oe, 1);
        check("m0 poci bit7", poci, 1);
        spi_xfer(2'd0, 8'h3C, 8, miso);
        cs_high();
        check("m0 miso", miso, 8'hA5);
        check("m0 rx_data", rx_data, 8'h3C);
        check("m0 rx_valid count", rx_count - rx_base, 1);
        // The final trailing edge is a shift edge, so a second byte start finds the buffer empty.
        check("m0 underrun count", ur_count - ur_base, 1);
        check("m0 idle busy", busy, 0);
        check("m0 idle poci_oe", poci_oe, 0);
        check("m0 idle poci", poci, 0);

        // Mode 3, two bytes under one cs.
        cpol = 1'b1; cpha = 1'b1; sclk = 1'b1;
        write_tx(8'h81);
        wait_cycles(HALF);
        rx_base = rx_count; ur_base = ur_count;
        cs_low();
        spi_xfer(2'd3, 8'hC3, 8, miso);
        write_tx(8'h7E);
        wait_cycles(6);
        check("m3 first rx_data", rx_data, 8'hC3);
        check("m3 first rx count", rx_count - rx_base, 1);
        spi_xfer(2'd3, 8'h5A, 8, miso2);
        cs_high();
        check("m3 miso byte1", miso, 8'h81);
        check("m3 miso byte2", miso2, 8'h7E);
        check("m3 rx_data byte2", rx_data, 8'h5A);
        check("m3 rx count", rx_count - rx_base, 2);
        check("m3 underrun count", ur_count - ur_base, 0);

        // Mode 1, empty buffer.
        cpol = 1'b0; cpha = 1'b1; sclk = 1'b0;
        wait_cycles(HALF);
        rx_base = rx_count; ur_base = ur_count;
        cs_low();
        check("m1 underrun at start", ur_count - ur_base, 1);
        spi_xfer(2'd1, 8'h96, 8, miso);
        cs_high();
        check("m1 miso", miso, 8'h00);
        check("m1 rx_data", rx_data, 8'h96);
        check("m1 rx count", rx_count - rx_base, 1);
        check("m1 underrun count", ur_count - ur_base, 1);

        // Mode 2, empty buffer.
        cpol = 1'b1; cpha = 1'b0; sclk = 1'b1;
        wait_cycles(HALF);
        rx_base = rx_count; ur_base = ur_count;
        cs_low();
        check("m2 underrun at start", ur_count - ur_base, 1);
        spi_xfer(2'd2, 8'h69, 8, miso);
        cs_high();
        check("m2 miso", miso, 8'h00);
        check("m2 rx_data", rx_data, 8'h69);
        check("m2 rx count", rx_count - rx_base, 1);
        check("m2 underrun count", ur_count - ur_base, 2);

        // Mode 0, cs released after 5 bits; buffered byte must survive.
        cpol = 1'b0; cpha = 1'b0; sclk = 1'b0;
        wait_cycles(HALF);
        rx_base = rx_count;
        cs_low();
        write_tx(8'hC6);
        spi_xfer(2'd0, 8'hFF, 5, miso);
        cs_high();
        check("abort rx count", rx_count - rx_base, 0);
        check("abort rx_data held", rx_data, 8'h69);
        check("abort buffer kept", tx_ready, 0);
        cs_low();
        spi_xfer(2'd0, 8'hF0, 8, miso);
        cs_high();
        check("after abort rx_data", rx_data, 8'hF0);
        check("after abort rx count", rx_count - rx_base, 1);
        check("after abort miso", miso, 8'hC6);

        // Mode 1, tx_write in the very cycle the cs-fall byte start happens.
        cpol = 1'b0; cpha = 1'b1;
        wait_cycles(HALF);
        cs = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("race busy before start", busy, 0);
        tx_data  = 8'h55;
        tx_write = 1'b1;
        @(negedge clock);
        tx_write = 1'b0;
        check("race busy", busy, 1);
        check("race underrun pulse", underrun, 1);
        check("race write accepted", tx_ready, 0);
        spi_xfer(2'd1, 8'h11, 8, miso);
        spi_xfer(2'd1, 8'h22, 8, miso2);
        cs_high();
        check("race miso byte1", miso, 8'h00);
        check("race miso byte2", miso2, 8'h55);
        check("race rx_data", rx_data, 8'h22);

        // Mode 0, reset in the middle of a byte.
        cpol = 1'b0; cpha = 1'b0;
        write_tx(8'h99);
        wait_cycles(HALF);
        cs_low();
        write_tx(8'h42);
        spi_xfer(2'd0, 8'hAA, 4, miso);
        wait_cycles(HALF);
        check("pre-reset busy", busy, 1);
        check("pre-reset poci bit3", poci, 1);
        check("pre-reset tx_ready", tx_ready, 0);
        reset = 1'b1;
        cs    = 1'b1;
        @(negedge clock);
        check("midreset poci", poci, 0);
        check("midreset poci_oe", poci_oe, 0);
        check("midreset tx_ready", tx_ready, 1);
        check("midreset rx_data", rx_data, 8'h00);
        check("midreset rx_valid", rx_valid, 0);
        check("midreset busy", busy, 0);
        check("midreset underrun", underrun, 0);
        wait_cycles(4);
        reset = 1'b0;
        rx_base = rx_count; ur_base = ur_count;
        for (int i = 0; i < 10; i++) begin
            pico = i[0];
            wait_cycles(HALF);
            sclk = ~sclk;
        end
        wait_cycles(HALF);
        check("cs high busy", busy, 0);
        check("cs high poci_oe", poci_oe, 0);
        check("cs high poci", poci, 0);
        check("cs high rx count", rx_count - rx_base, 0);
        check("cs high underrun count", ur_count - ur_base, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
